cosim_vec_capture: RTL and testbench



---
 rtl/cosim_vec_capture.sv | 228 ++++++++++++++++++++++
 tb/tb_cosim_vec_capture.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/cosim_vec_capture.sv
// ---------------------------------------------------------------------------
// cosim_vec_capture
//
// Capture stage at the end of a cosim design under test. Every result vector
// offered on the input handshake is accepted into a small FIFO (drained by
// the trace dumper). Each accepted vector is also folded into a running MISR
// signature, and a saturating beat counter is incremented. A testbench can
// then compare one signature against the reference simulator instead of
// comparing every vector.
//
// Parameters
//   WIDTH  vector width (>= 2)
//   DEPTH  FIFO entries (power of two, >= 2)
//   POLY   MISR feedback polynomial (low WIDTH bits)
//
// Ports
//   clk        clock
//   rst_n      asynchronous active-low reset; clears all state, FIFO included
//   in_valid   producer offers in_vec
//   in_vec     result vector
//   in_ready   FIFO not full (accept = in_valid && in_ready)
//   out_valid  FIFO not empty
//   out_vec    FIFO head entry
//   out_ready  consumer takes the head (pop = out_valid && out_ready)
//   clear      synchronous clear of sig / count / x_seen (FIFO untouched)
//   sig        running MISR signature
//   count      accepted-beat count, saturates at all-ones
//   x_seen     sticky flag: an accepted beat carried an X/Z bit
//
// Build option
//   COSIM_CAPTURE_XCHECK_EN  when defined, accepted beats are checked for
//                            X/Z bits and x_seen becomes a sticky flag.
//                            When undefined, x_seen is tied low and no check
//                            logic exists.
// ---------------------------------------------------------------------------
module cosim_vec_capture #(
    parameter int              WIDTH = 128,
    parameter int              DEPTH = 8,
    parameter logic [WIDTH-1:0] POLY = WIDTH'(128'h87)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [WIDTH-1:0]  in_vec,
    output logic              in_ready,
    output logic              out_valid,
    output logic [WIDTH-1:0]  out_vec,
    input  logic              out_ready,
    input  logic              clear,
    output logic [WIDTH-1:0]  sig,
    output logic [31:0]       count,
    output logic              x_seen
);

    // Pointer address width plus one wrap bit to tell full from empty.
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    localparam logic [PW-1:0] PTR_ONE   = PW'(1);
    localparam logic [31:0]   COUNT_MAX = 32'hFFFF_FFFF;

    // -----------------------------------------------------------------------
    // MISR step: shift left, apply feedback when the bit shifted out was set,
    // then fold in the new vector.
    // -----------------------------------------------------------------------
    function automatic logic [WIDTH-1:0] misr_step(
        input logic [WIDTH-1:0] cur,
        input logic [WIDTH-1:0] vec
    );
        logic [WIDTH-1:0] fb;
        if (cur[WIDTH-1]) begin
            fb = POLY;
        end else begin
            fb = {WIDTH{1'b0}};
        end
        return {cur[WIDTH-2:0], 1'b0} ^ fb ^ vec;
    endfunction

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q;
    logic [PW-1:0]    rd_ptr_d;
    logic [WIDTH-1:0] sig_q;
    logic [WIDTH-1:0] sig_d;
    logic [31:0]      count_q;
    logic [31:0]      count_d;

    logic             full_s;
    logic             empty_s;
    logic             push_s;
    logic             pop_s;

    // Occupancy flags come straight from the registered pointers, so a pop
    // in the same cycle never frees space for a push in that cycle.
    always_comb begin
        empty_s = (wr_ptr_q == rd_ptr_q);
        full_s  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    end

    // Handshake qualification for both FIFO ports.
    always_comb begin
        push_s = in_valid && !full_s;
        pop_s  = out_ready && !empty_s;
    end

    // Next-state pointers: each advances independently, so push+pop keeps
    // occupancy unchanged.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
    end

    // Pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= {PW{1'b0}};
            rd_ptr_q <= {PW{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // FIFO storage; reset to zero so out_vec reads zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {WIDTH{1'b0}};
            end
        end else if (push_s) begin
            mem_q[wr_ptr_q[AW-1:0]] <= in_vec;
        end else begin
            mem_q[wr_ptr_q[AW-1:0]] <= mem_q[wr_ptr_q[AW-1:0]];
        end
    end

    // Signature and beat counter. A clear is applied before a simultaneous
    // accept, so clear+accept leaves sig = in_vec and count = 1.
    always_comb begin
        sig_d   = sig_q;
        count_d = count_q;
        if (clear) begin
            sig_d   = {WIDTH{1'b0}};
            count_d = 32'd0;
        end else begin
            sig_d   = sig_q;
            count_d = count_q;
        end
        if (push_s) begin
            sig_d = misr_step(sig_d, in_vec);
            if (count_d != COUNT_MAX) begin
                count_d = count_d + 32'd1;
            end else begin
                count_d = COUNT_MAX;
            end
        end else begin
            sig_d   = sig_d;
            count_d = count_d;
        end
    end

    // Signature and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_q   <= {WIDTH{1'b0}};
            count_q <= 32'd0;
        end else begin
            sig_q   <= sig_d;
            count_q <= count_d;
        end
    end

`ifdef COSIM_CAPTURE_XCHECK_EN
    logic x_hit_s;
    logic x_seen_q;
    logic x_seen_d;

    // Four-state check of an accepted beat; X bits still reach the MISR.
    always_comb begin
        x_hit_s = push_s && $isunknown(in_vec);
    end

    // Sticky flag, with clear taking effect before a same-cycle hit.
    always_comb begin
        if (clear) begin
            x_seen_d = x_hit_s;
        end else begin
            x_seen_d = x_seen_q | x_hit_s;
        end
    end

    // X-seen register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_seen_q <= 1'b0;
        end else begin
            x_seen_q <= x_seen_d;
        end
    end

    assign x_seen = x_seen_q;
`else
    assign x_seen = 1'b0;
`endif

    // Outputs: all derived directly from registered state.
    assign in_ready  = !full_s;
    assign out_valid = !empty_s;
    assign out_vec   = mem_q[rd_ptr_q[AW-1:0]];
    assign sig       = sig_q;
    assign count     = count_q;

endmodule

// File: tb/tb_cosim_vec_capture.sv
// ---------------------------------------------------------------------------
// Self-checking bench for cosim_vec_capture (WIDTH=128, DEPTH=8, POLY=0x87).
// A table of stimulus records with hand-computed signatures/counts drives the
// main sequence; a scoreboard queue holds the expected FIFO contents and an
// independent occupancy/MISR model supplies the remaining expectations.
// ---------------------------------------------------------------------------
module tb_cosim_vec_capture;

    localparam int W = 128;
    localparam int D = 8;
    localparam logic [W-1:0] P = 128'h87;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic [W-1:0]  in_vec = '0;
    logic          in_ready;
    logic          out_valid;
    logic [W-1:0]  out_vec;
    logic          out_ready = 1'b0;
    logic          clear = 1'b0;
    logic [W-1:0]  sig;
    logic [31:0]   count;
    logic          x_seen;

    cosim_vec_capture #(.WIDTH(W), .DEPTH(D), .POLY(P)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_vec    (in_vec),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_vec   (out_vec),
        .out_ready (out_ready),
        .clear     (clear),
        .sig       (sig),
        .count     (count),
        .x_seen    (x_seen)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [W-1:0] sb_q [$];
    logic [W-1:0] m_sig = '0;
    logic [31:0]  m_cnt = '0;
    logic         m_x   = 1'b0;

    typedef struct {
        logic         v;
        logic [W-1:0] vec;
        logic         ordy;
        logic         clr;
        logic [W-1:0] esig;
        logic [31:0]  ecnt;
    } vec_t;

    vec_t tbl [11];

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] misr_ref(input logic [W-1:0] s, input logic [W-1:0] v);
        logic [W-1:0] r;
        r = s << 1;
        if (s[W-1] === 1'b1) r = r ^ P;
        return r ^ v;
    endfunction

    // One clock cycle: check pre-edge state, drive, update model, check post-edge.
    task automatic cycle(input logic v, input logic [W-1:0] vec, input logic ordy, input logic clr);
        bit acc;
        bit pop;
        chk("in_ready", W'(in_ready), W'(sb_q.size() < D));
        chk("out_valid", W'(out_valid), W'(sb_q.size() > 0));
        if (sb_q.size() > 0) chk("out_vec", out_vec, sb_q[0]);
        in_valid  = v;
        in_vec    = vec;
        out_ready = ordy;
        clear     = clr;
        acc = v && (sb_q.size() < D);
        pop = ordy && (sb_q.size() > 0);
        @(posedge clk);
        if (pop) void'(sb_q.pop_front());
        if (acc) sb_q.push_back(vec);
        if (clr) begin
            m_sig = '0;
            m_cnt = '0;
            m_x   = 1'b0;
        end
        if (acc) begin
            m_sig = misr_ref(m_sig, vec);
            if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
`ifdef COSIM_CAPTURE_XCHECK_EN
            if ($isunknown(vec)) m_x = 1'b1;
`endif
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        clear     = 1'b0;
        chk("sig", sig, m_sig);
        chk("count", W'(count), W'(m_cnt));
        chk("x_seen", W'(x_seen), W'(m_x));
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 3 * D && sb_q.size() > 0; i++) cycle(1'b0, '0, 1'b1, 1'b0);
        chk({name, "_drained"}, W'(sb_q.size()), W'(0));
        chk({name, "_out_valid_end"}, W'(out_valid), W'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [W-1:0] xv;

        //               v     vec                                      ordy  clr   exp sig                                  cnt
        tbl[0]  = '{1'b1, 128'h3F,                                 1'b0, 1'b0, 128'h3F,                                 32'd1};
        tbl[1]  = '{1'b0, 128'h0,                                  1'b1, 1'b1, 128'h0,                                  32'd0};
        tbl[2]  = '{1'b1, 128'h1,                                  1'b0, 1'b0, 128'h1,                                  32'd1};
        tbl[3]  = '{1'b1, 128'h2,                                  1'b1, 1'b0, 128'h0,                                  32'd2};
        tbl[4]  = '{1'b0, 128'h0,                                  1'b1, 1'b0, 128'h0,                                  32'd2};
        tbl[5]  = '{1'b1, 128'h1,                                  1'b0, 1'b1, 128'h1,                                  32'd1};
        tbl[6]  = '{1'b1, 128'h0,                                  1'b0, 1'b0, 128'h2,                                  32'd2};
        tbl[7]  = '{1'b1, 128'h1,                                  1'b0, 1'b0, 128'h5,                                  32'd3};
        tbl[8]  = '{1'b1, 128'hA,                                  1'b0, 1'b1, 128'hA,                                  32'd1};
        tbl[9]  = '{1'b1, 128'h8000_0000_0000_0000_0000_0000_0000_0000, 1'b0, 1'b0, 128'h8000_0000_0000_0000_0000_0000_0000_0014, 32'd2};
        tbl[10] = '{1'b1, 128'h0,                                  1'b0, 1'b0, 128'hAF,                                 32'd3};

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_in_ready", W'(in_ready), W'(1));
        chk("rst_out_valid", W'(out_valid), W'(0));
        chk("rst_out_vec", out_vec, '0);
        chk("rst_sig", sig, '0);
        chk("rst_count", W'(count), W'(0));
        chk("rst_x_seen", W'(x_seen), W'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // Table-driven main sequence: single beat, fold, clear+accept, feedback
        for (int i = 0; i < 11; i++) begin
            cycle(tbl[i].v, tbl[i].vec, tbl[i].ordy, tbl[i].clr);
            chk($sformatf("tbl%0d_sig", i), sig, tbl[i].esig);
            chk($sformatf("tbl%0d_count", i), W'(count), W'(tbl[i].ecnt));
        end
        // FIFO kept 1,0,1,A across the clear plus the two later beats
        chk("fifo_kept", W'(sb_q.size()), W'(6));
        drain("tbl");

        // Full / wrap, twice so both pointers wrap
        for (int r = 0; r < 2; r++) begin
            for (int i = 1; i <= D; i++) cycle(1'b1, W'(i), 1'b0, 1'b0);
            chk("full_in_ready", W'(in_ready), W'(0));
            cycle(1'b1, W'(9), 1'b0, 1'b0);          // held, not accepted
            cycle(1'b1, W'(9), 1'b1, 1'b0);          // pop + push while full
            chk("after_pop_in_ready", W'(in_ready), W'(1));
            chk("after_pop_count", W'(count), W'(m_cnt));
            drain($sformatf("wrap%0d", r));
        end

        // Asynchronous reset mid-stream
        cycle(1'b1, 128'h11, 1'b0, 1'b0);
        cycle(1'b1, 128'h22, 1'b0, 1'b0);
        cycle(1'b1, 128'h33, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", W'(out_valid), W'(0));
        chk("arst_in_ready", W'(in_ready), W'(1));
        chk("arst_sig", sig, '0);
        chk("arst_count", W'(count), W'(0));
        chk("arst_out_vec", out_vec, '0);
        #1 rst_n = 1'b1;
        sb_q.delete();
        m_sig = '0;
        m_cnt = '0;
        m_x   = 1'b0;
        @(negedge clk);
        cycle(1'b1, 128'h55, 1'b0, 1'b0);
        drain("post_rst");

        // X check (sticky when enabled, constant 0 otherwise)
        xv = 128'h0;
        xv[0] = 1'bx;
        cycle(1'b1, xv, 1'b0, 1'b0);
        cycle(1'b1, 128'h3, 1'b0, 1'b0);
`ifdef COSIM_CAPTURE_XCHECK_EN
        chk("x_sticky", W'(x_seen), W'(1));
`else
        chk("x_tied_low", W'(x_seen), W'(0));
`endif
        cycle(1'b0, '0, 1'b0, 1'b1);
        chk("x_after_clear", W'(x_seen), W'(0));
        drain("x");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
